// File: rtl/nx_fifo_rd_stream.sv
// rtl/nx_fifo_rd_stream.sv - RAM FIFO consumer: read-latency absorption, skid buffer, valid/ready output
// Error beats are tagged per entry and counted; clear flushes buffered and in-flight reads.
module nx_fifo_rd_stream #(
    parameter int WIDTH      = 71,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = RD_LATENCY + 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           fifo_empty,
    output logic                           fifo_ren,
    input  logic [WIDTH-1:0]               fifo_rdata,
    input  logic                           fifo_rerr,
    input  logic                           clear,
    input  logic                           stat_clr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_err,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_used,
    output logic [15:0]                    err_cnt,
    output logic                           err_sticky
);
    localparam int UW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic                  en_q;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [UW-1:0]         used_q, used_d;
    logic [WIDTH:0]        mem_q [BUF_DEPTH];
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic                  err_sticky_q, err_sticky_d;
    logic [UW:0]           pending;
    logic                  wr, pop, ret_err;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit check counts buffered entries plus reads still in the RAM pipeline.
    always_comb begin
        pending = {1'b0, used_q};
        for (int i = 0; i < RD_LATENCY; i++) begin
            pending = pending + (UW+1)'(vld_q[i]);
        end
    end

    assign fifo_ren  = en_q && !fifo_empty && !clear && (pending < (UW+1)'(BUF_DEPTH));
    assign out_valid = (used_q != '0);
    assign pop       = out_valid && out_ready;
    assign wr        = vld_q[RD_LATENCY-1] && !clear;
    assign ret_err   = wr && fifo_rerr;

    assign {out_err, out_data} = mem_q[rptr_q];
    assign buf_used   = used_q;
    assign err_cnt    = err_cnt_q;
    assign err_sticky = err_sticky_q;

    always_comb begin
        vld_d  = '0;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        used_d = used_q;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            used_d = '0;
        end else begin
            vld_d[0] = fifo_ren;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
            end
            if (wr)  wptr_d = ptr_inc(wptr_q);
            if (pop) rptr_d = ptr_inc(rptr_q);
            case ({wr, pop})
                2'b10:   used_d = used_q + 1'b1;
                2'b01:   used_d = used_q - 1'b1;
                default: used_d = used_q;
            endcase
        end

        // A clear of the statistics still records an error beat landing that cycle.
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (stat_clr) begin
            err_cnt_d    = {15'd0, ret_err};
            err_sticky_d = ret_err;
        end else if (ret_err) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q         <= 1'b0;
            vld_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            used_q       <= '0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            en_q         <= 1'b1;
            vld_q        <= vld_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            used_q       <= used_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
            if (wr) mem_q[wptr_q] <= {fifo_rerr, fifo_rdata};
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        wr |-> (used_q != UW'(BUF_DEPTH)));
`endif
endmodule

// File: tb/tb_nx_fifo_rd_stream.sv
// tb/tb_nx_fifo_rd_stream.sv - randomized scoreboard bench over RD_LATENCY 1..3
module tb_nx_fifo_rd_stream;
    localparam int W = 71;

    typedef struct packed {logic v; logic err; logic [W-1:0] data;} beat_t;
    typedef struct packed {beat_t b; logic [31:0] t;} pend_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clear, out_ready;
    logic fifo_empty [3];
    logic fifo_ren   [3];
    logic fifo_rerr  [3];
    logic out_valid  [3];
    logic out_err    [3];
    logic err_sticky [3];
    logic stat_clr   [3];
    logic [W-1:0] fifo_rdata [3];
    logic [W-1:0] out_data   [3];
    logic [3:0]   buf_used   [3];
    logic [15:0]  err_cnt    [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int L  = k + 1;
        localparam int BD = L + 2;
        logic ren, ov, oe, es;
        logic [W-1:0] od;
        logic [15:0] ec;
        logic [$clog2(BD+1)-1:0] bu;
        nx_fifo_rd_stream #(.WIDTH(W), .RD_LATENCY(L), .BUF_DEPTH(BD)) u_dut (
            .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[k]), .fifo_ren(ren),
            .fifo_rdata(fifo_rdata[k]), .fifo_rerr(fifo_rerr[k]), .clear(clear),
            .stat_clr(stat_clr[k]), .out_valid(ov), .out_ready(out_ready), .out_data(od),
            .out_err(oe), .buf_used(bu), .err_cnt(ec), .err_sticky(es)
        );
        assign fifo_ren[k]   = ren;
        assign out_valid[k]  = ov;
        assign out_err[k]    = oe;
        assign out_data[k]   = od;
        assign buf_used[k]   = 4'(bu);
        assign err_cnt[k]    = ec;
        assign err_sticky[k] = es;
    end

    beat_t fq [3][$];
    pend_t pq [3][$];
    beat_t pipe [3][3];
    logic [15:0] m_cnt [3];
    logic m_sticky [3];
    int checks = 0, errors = 0, cyc = 0;
    logic hold_empty = 1'b0, clr_on_err = 1'b0;
    int beats [3];
    int max_used0;
    logic arm [3];
    logic [31:0] first_seq [3];
    int pushed [3];

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        return W'({$urandom, $urandom, $urandom});
    endfunction

    task automatic load(input int n, input logic [31:0] errbits);
        beat_t b;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < n; i++) begin
                b.v    = 1'b1;
                b.err  = (i < 32) ? errbits[i] : 1'b0;
                b.data = {39'($urandom), 32'(i)};
                fq[k].push_back(b);
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            pq[k].delete();
            m_cnt[k]    = 16'd0;
            m_sticky[k] = 1'b0;
        end
    endtask

    task automatic chk_zero(input string ph);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_ren%0d", ph, k),   72'(fifo_ren[k]),   72'(0));
            chk($sformatf("%s_valid%0d", ph, k), 72'(out_valid[k]),  72'(0));
            chk($sformatf("%s_data%0d", ph, k),  72'(out_data[k]),   72'(0));
            chk($sformatf("%s_err%0d", ph, k),   72'(out_err[k]),    72'(0));
            chk($sformatf("%s_used%0d", ph, k),  72'(buf_used[k]),   72'(0));
            chk($sformatf("%s_cnt%0d", ph, k),   72'(err_cnt[k]),    72'(0));
            chk($sformatf("%s_stk%0d", ph, k),   72'(err_sticky[k]), 72'(0));
        end
    endtask

    // One clock: drive inputs, check against the transaction model, advance the model.
    task automatic cycle();
        for (int k = 0; k < 3; k++) begin
            int lat;
            lat = k + 1;
            fifo_empty[k] = hold_empty || (fq[k].size() == 0);
            if (pipe[k][lat-1].v) begin
                fifo_rdata[k] = pipe[k][lat-1].data;
                fifo_rerr[k]  = pipe[k][lat-1].err;
            end else begin
                fifo_rdata[k] = rnd_data();
                fifo_rerr[k]  = 1'($urandom);
            end
            if (clr_on_err) begin
                stat_clr[k] = 1'b0;
                for (int j = 0; j < pq[k].size(); j++)
                    if (cyc - int'(pq[k][j].t) == lat && pq[k][j].b.err) stat_clr[k] = 1'b1;
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            int lat, nbuf;
            logic ev, er, rerr;
            beat_t nb;
            lat  = k + 1;
            nbuf = 0;
            rerr = 1'b0;
            for (int j = 0; j < pq[k].size(); j++) begin
                if (cyc - int'(pq[k][j].t) >= lat + 1) nbuf++;
                if (cyc - int'(pq[k][j].t) == lat && pq[k][j].b.err && !clear) rerr = 1'b1;
            end
            ev = (nbuf != 0);
            er = !fifo_empty[k] && !clear && (pq[k].size() < lat + 2);
            chk($sformatf("ren%0d", k),   72'(fifo_ren[k]),   72'(er));
            chk($sformatf("valid%0d", k), 72'(out_valid[k]),  72'(ev));
            chk($sformatf("used%0d", k),  72'(buf_used[k]),   72'(nbuf));
            chk($sformatf("cnt%0d", k),   72'(err_cnt[k]),    72'(m_cnt[k]));
            chk($sformatf("stk%0d", k),   72'(err_sticky[k]), 72'(m_sticky[k]));
            if (ev) begin
                chk($sformatf("data%0d", k), 72'(out_data[k]), 72'(pq[k][0].b.data));
                chk($sformatf("oerr%0d", k), 72'(out_err[k]),  72'(pq[k][0].b.err));
            end
            if (out_valid[k] && out_ready) begin
                beats[k]++;
                if (arm[k]) begin
                    first_seq[k] = out_data[k][31:0];
                    arm[k] = 1'b0;
                end
            end
            if (k == 0 && int'(buf_used[0]) > max_used0) max_used0 = int'(buf_used[0]);

            if (stat_clr[k]) begin
                m_cnt[k]    = {15'd0, rerr};
                m_sticky[k] = rerr;
            end else if (rerr) begin
                if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
                m_sticky[k] = 1'b1;
            end
            if (ev && out_ready) void'(pq[k].pop_front());
            if (clear) pq[k].delete();
            nb = '0;
            if (er) begin
                nb = fq[k].pop_front();
                pq[k].push_back({nb, 32'(cyc)});
            end
            for (int i = lat - 1; i > 0; i--) pipe[k][i] = pipe[k][i-1];
            pipe[k][0] = nb;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        int left, n;
        logic [31:0] clr_exp [3];
        clr_exp[0] = 32'd3; clr_exp[1] = 32'd4; clr_exp[2] = 32'd4;
        rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0; max_used0 = 0;
        for (int k = 0; k < 3; k++) begin
            fifo_empty[k] = 1'b1; fifo_rerr[k] = 1'b0; fifo_rdata[k] = '0;
            stat_clr[k] = 1'b0; beats[k] = 0; arm[k] = 1'b0; first_seq[k] = '0; pushed[k] = 0;
            for (int i = 0; i < 3; i++) pipe[k][i] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
        hold_empty = 1'b1; cycle(); hold_empty = 1'b0;

        // Streaming at full rate
        load(100, 32'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) beats[k] = 0;
        run(110);
        chk("stream_max_used0", 72'(max_used0 > 3), 72'(0));
        for (int k = 0; k < 3; k++) chk($sformatf("stream_beats%0d", k), 72'(beats[k]), 72'(100));

        // Backpressure
        load(20, 32'h0);
        out_ready = 1'b0;
        run(10);
        chk("bp_used1", 72'(buf_used[1]), 72'(4));
        out_ready = 1'b1;
        run(30);

        // Clear with reads buffered and in flight
        load(20, 32'h0);
        out_ready = 1'b0;
        run(4);
        clear = 1'b1; cycle(); clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("clr_used%0d", k), 72'(buf_used[k]), 72'(0));
            arm[k] = 1'b1;
        end
        out_ready = 1'b1;
        run(30);
        for (int k = 0; k < 3; k++) chk($sformatf("clr_next%0d", k), 72'(first_seq[k]), 72'(clr_exp[k]));

        // Error tagging and statistics
        for (int k = 0; k < 3; k++) stat_clr[k] = 1'b1;
        cycle();
        for (int k = 0; k < 3; k++) stat_clr[k] = 1'b0;
        load(12, 32'h88);
        run(20);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("err_cnt%0d", k), 72'(err_cnt[k]),    72'(2));
            chk($sformatf("err_stk%0d", k), 72'(err_sticky[k]), 72'(1));
        end
        load(8, 32'h10);
        clr_on_err = 1'b1;
        run(15);
        clr_on_err = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stat_clr[k] = 1'b0;
            chk($sformatf("clr_err_cnt%0d", k), 72'(err_cnt[k]), 72'(1));
        end

        // Saturation from a preset count
        force g[0].u_dut.err_cnt_q = 16'hFFFE;
        force g[1].u_dut.err_cnt_q = 16'hFFFE;
        force g[2].u_dut.err_cnt_q = 16'hFFFE;
        #1;
        release g[0].u_dut.err_cnt_q;
        release g[1].u_dut.err_cnt_q;
        release g[2].u_dut.err_cnt_q;
        for (int k = 0; k < 3; k++) m_cnt[k] = 16'hFFFE;
        load(10, 32'h52);
        run(20);
        for (int k = 0; k < 3; k++) chk($sformatf("sat_cnt%0d", k), 72'(err_cnt[k]), 72'(16'hFFFF));

        // Asynchronous reset in the middle of a stream
        load(30, 32'h0);
        run(8);
        #2 rst_n = 1'b0;
        #1 chk_zero("mid");
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        hold_empty = 1'b1; cycle(); hold_empty = 1'b0;
        run(60);

        // Random ready, refill, clear and statistics clear
        n = 0;
        left = 1;
        while (left != 0 && n < 8000) begin
            beat_t b;
            for (int k = 0; k < 3; k++) begin
                if (pushed[k] < 1000 && ($urandom % 2) == 1) begin
                    b.v = 1'b1; b.err = (($urandom % 8) == 0);
                    b.data = {39'($urandom), 32'(pushed[k])};
                    fq[k].push_back(b);
                    pushed[k]++;
                end
                stat_clr[k] = (($urandom % 50) == 0);
            end
            out_ready = 1'($urandom);
            clear = (($urandom % 64) == 0);
            cycle();
            n++;
            left = 0;
            for (int k = 0; k < 3; k++) left += (1000 - pushed[k]) + fq[k].size() + pq[k].size();
        end
        clear = 1'b0;
        for (int k = 0; k < 3; k++) stat_clr[k] = 1'b0;
        chk("rand_drain", 72'(left), 72'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
